// File: rtl/header_miner_ctrl.sv
// Nonce-sweep controller for a sha256 core: loads an 80-byte header byte-serially,
// walks the little-endian nonce field and stops on the first hash meeting the zero mask.
module header_miner_ctrl #(
  parameter int ZBITS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   din,
  input  logic         din_valid,
  input  logic         go,
  input  logic         abort,
  output logic [639:0] block,
  output logic         sha_start,
  input  logic         sha_done,
  input  logic [255:0] sha_hash,
  output logic         loaded,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic [31:0]  nonce_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HASH_START,
    S_HASH_WAIT,
    S_CHECK,
    S_FOUND,
    S_EXHAUSTED
  } state_e;

  localparam logic [255:0] ZMASK = (256'd1 << ZBITS) - 256'd1;

  state_e       state_q, state_d;
  logic [607:0] hdr_q, hdr_d;      // header bytes 0..75; bytes 76..79 live in n_q
  logic [6:0]   cnt_q, cnt_d;
  logic [31:0]  n_q, n_d;
  logic         loaded_q, loaded_d;
  logic         win_q, win_d;
  logic         start_q;
  logic         take;
  logic [9:0]   base;

  assign busy = (state_q == S_HASH_START) || (state_q == S_HASH_WAIT) || (state_q == S_CHECK);
  assign take = din_valid && !busy;
  assign base = 10'd607 - {cnt_q, 3'b000};

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    loaded_d = loaded_q;
    win_d    = win_q;

    if (take) begin
      if (cnt_q < 7'd76) begin
        hdr_d[base -: 8] = din;
      end else begin
        case (cnt_q)
          7'd76:   n_d[7:0]   = din;
          7'd77:   n_d[15:8]  = din;
          7'd78:   n_d[23:16] = din;
          7'd79:   n_d[31:24] = din;
          default: ;
        endcase
      end
      cnt_d = (cnt_q == 7'd79) ? 7'd0 : cnt_q + 7'd1;
      if (cnt_q == 7'd79)     loaded_d = 1'b1;
      else if (cnt_q == 7'd0) loaded_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE:       if (go && loaded_q) state_d = S_HASH_START;
      S_HASH_START: state_d = S_HASH_WAIT;
      S_HASH_WAIT: begin
        if (sha_done) begin
          win_d   = ((sha_hash & ZMASK) == '0);
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (win_q) begin
          state_d = S_FOUND;
        end else if (n_q == '1) begin
          state_d = S_EXHAUSTED;
        end else if (!abort) begin
          n_d     = n_q + 32'd1;
          state_d = S_HASH_START;
        end
      end
      S_FOUND, S_EXHAUSTED: begin
        // go uses the pre-edge loaded flag, even if a new byte 0 lands this cycle
        if (go && loaded_q)                      state_d = S_HASH_START;
        else if (go || (take && cnt_q == 7'd0))  state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) state_d = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hdr_q    <= '0;
      cnt_q    <= '0;
      n_q      <= '0;
      loaded_q <= 1'b0;
      win_q    <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      loaded_q <= loaded_d;
      win_q    <= win_d;
      start_q  <= (state_d == S_HASH_START);
    end
  end

  // start comes straight from a flop so it cannot glitch while the state decodes
  assign sha_start = start_q;
  assign block     = {hdr_q, n_q[7:0], n_q[15:8], n_q[23:16], n_q[31:24]};
  assign loaded    = loaded_q;
  assign found     = (state_q == S_FOUND);
  assign exhausted = (state_q == S_EXHAUSTED);
  assign nonce_out = n_q;

endmodule

// File: tb/tb_header_miner_ctrl.sv
// Scoreboard bench for header_miner_ctrl with a behavioural sha256 core model
// whose hash wins only for one chosen nonce.
module tb_header_miner_ctrl;

  localparam logic [639:0] GEN = {32'h01000000, 256'h0,
    256'h3BA3EDFD7A7B12B27AC72C3E67768F617FC81BC3888A51323A9FB8AA4B1E5E4A,
    32'h29AB5F49, 32'hFFFF001D, 32'h1DAC2B7C};
  localparam logic [31:0] WIN_NONCE = 32'h7C2BAC1D;

  localparam logic [1:0] EV_START = 2'd0;
  localparam logic [1:0] EV_FOUND = 2'd1;
  localparam logic [1:0] EV_EXH   = 2'd2;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] nonce;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   din;
  logic         din_valid;
  logic         go;
  logic         abort;
  logic [639:0] block;
  logic         sha_start;
  logic         sha_done;
  logic [255:0] sha_hash;
  logic         loaded;
  logic         busy;
  logic         found;
  logic         exhausted;
  logic [31:0]  nonce_out;

  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;
  int   lat = 1;
  bit   mode_ones = 1'b0;
  exp_t exp_q[$];

  header_miner_ctrl #(.ZBITS(32)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .go(go), .abort(abort),
    .block(block), .sha_start(sha_start), .sha_done(sha_done), .sha_hash(sha_hash),
    .loaded(loaded), .busy(busy), .found(found), .exhausted(exhausted), .nonce_out(nonce_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // winner has zero low 32 bits but nonzero upper bits; losers only have bit 31 set
  function automatic logic [255:0] hash_for(input logic [31:0] n);
    if (mode_ones)          return '1;
    else if (n == WIN_NONCE) return {224'hC0FFEE, 32'h0};
    else                    return {224'h0, 32'h8000_0000};
  endfunction

  task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [31:0] nonce);
    exp_t e;
    e.kind  = kind;
    e.nonce = nonce;
    exp_q.push_back(e);
  endtask

  task automatic sb_event(input logic [1:0] kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got event %0d nonce %h, expected no event", kind, nonce_out);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", kind, e.kind);
      check("sb_nonce", nonce_out, e.nonce);
      if (kind == EV_START) check("sb_block_lo", block[31:0], swap32(e.nonce));
    end
  endtask

  // behavioural sha256 core: done pulses after lat cycles of HASH_WAIT
  initial begin
    logic [31:0] seen;
    sha_done = 1'b0;
    sha_hash = '0;
    forever begin
      @(negedge clk);
      if (sha_start === 1'b1) begin
        seen = swap32(block[31:0]);
        repeat (lat) @(negedge clk);
        sha_hash = hash_for(seen);
        sha_done = 1'b1;
        @(negedge clk);
        sha_done = 1'b0;
        sha_hash = '0;
      end
    end
  end

  initial begin
    logic found_prev = 1'b0;
    logic exh_prev   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sha_start) begin
          start_cnt++;
          sb_event(EV_START);
        end
        if (found && !found_prev)    sb_event(EV_FOUND);
        if (exhausted && !exh_prev)  sb_event(EV_EXH);
      end
      found_prev = found;
      exh_prev   = exhausted;
    end
  end

  task automatic load_bytes(input logic [639:0] hdr, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      @(negedge clk);
      din       = hdr[639 - 8*k -: 8];
      din_valid = 1'b1;
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic go_pulse();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_timeout: got %0d pending events expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_block"}, block, '0);
    check({tag, "_loaded"}, loaded, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_found"}, found, 1'b0);
    check({tag, "_exhausted"}, exhausted, 1'b0);
    check({tag, "_sha_start"}, sha_start, 1'b0);
    check({tag, "_nonce_out"}, nonce_out, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [639:0] hdr;
    rst = 1'b1; din = '0; din_valid = 1'b0; go = 1'b0; abort = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // genesis header: wins on the first hash
    load_bytes(GEN, 0, 79);
    check("gen_block", block, GEN);
    check("gen_loaded", loaded, 1'b1);
    check("gen_nonce", nonce_out, WIN_NONCE);
    start_cnt = 0;
    push(EV_START, WIN_NONCE);
    push(EV_FOUND, WIN_NONCE);
    go_pulse();
    check("go_latency", sha_start, 1'b1);
    wait_empty(100);
    check("gen_found", found, 1'b1);
    check("gen_one_hash", start_cnt, 1);
    check("gen_busy", busy, 1'b0);

    // sweep 0x7C2BAC1A..0x7C2BAC1D
    hdr = GEN;
    hdr[31:0] = 32'h1AAC2B7C;
    load_bytes(hdr, 0, 79);
    check("sweep_idle", found, 1'b0);
    start_cnt = 0;
    for (int i = 0; i < 4; i++) push(EV_START, 32'h7C2BAC1A + i);
    push(EV_FOUND, WIN_NONCE);
    go_pulse();
    wait_empty(200);
    check("sweep_hashes", start_cnt, 4);
    check("sweep_block_lo", block[31:0], 32'h1DAC2B7C);
    check("sweep_block_hi", block[639:32], GEN[639:32]);

    // exhaustion with all-ones hash, then resume from the terminal state
    mode_ones = 1'b1;
    hdr[31:0] = 32'hFEFFFFFF;
    load_bytes(hdr, 0, 79);
    push(EV_START, 32'hFFFFFFFE);
    push(EV_START, 32'hFFFFFFFF);
    push(EV_EXH, 32'hFFFFFFFF);
    go_pulse();
    wait_empty(200);
    check("exh_flag", exhausted, 1'b1);
    check("exh_found", found, 1'b0);
    repeat (10) @(negedge clk);
    check("exh_no_wrap", nonce_out, 32'hFFFFFFFF);
    check("exh_hold", exhausted, 1'b1);
    push(EV_START, 32'hFFFFFFFF);
    push(EV_EXH, 32'hFFFFFFFF);
    go_pulse();
    wait_empty(100);
    check("exh_resume_nonce", nonce_out, 32'hFFFFFFFF);
    mode_ones = 1'b0;

    // abort during HASH_WAIT
    lat = 8;
    hdr[31:0] = 32'h00000000;
    load_bytes(hdr, 0, 79);
    push(EV_START, 32'h0);
    go_pulse();
    repeat (2) @(negedge clk);
    check("abort_pre_busy", busy, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_loaded", loaded, 1'b1);
    check("abort_nonce", nonce_out, 32'h0);
    check("abort_found", found, 1'b0);
    repeat (20) @(negedge clk);
    check("abort_no_start", exp_q.size(), 0);
    check("abort_still_idle", busy, 1'b0);

    // load rules: byte after complete header, go with 79 bytes, bytes while busy
    hdr = GEN;
    hdr[639:632] = 8'hA5;
    load_bytes(hdr, 0, 0);
    check("reload_loaded", loaded, 1'b0);
    check("reload_first_byte", block[639:632], 8'hA5);
    load_bytes(hdr, 1, 78);
    go_pulse();
    check("go_79_start", sha_start, 1'b0);
    repeat (5) @(negedge clk);
    check("go_79_busy", busy, 1'b0);
    load_bytes(hdr, 79, 79);
    check("full_loaded", loaded, 1'b1);
    check("full_block", block, hdr);
    lat = 6;
    push(EV_START, WIN_NONCE);
    push(EV_FOUND, WIN_NONCE);
    go_pulse();
    for (int i = 0; i < 5; i++) begin
      din       = 8'hEE;
      din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    wait_empty(100);
    check("busy_bytes_block", block, hdr);
    check("busy_bytes_loaded", loaded, 1'b1);
    check("busy_bytes_found", found, 1'b1);

    // asynchronous reset during HASH_WAIT
    lat = 10;
    hdr[31:0] = 32'h00000000;
    load_bytes(hdr, 0, 79);
    push(EV_START, 32'h0);
    go_pulse();
    repeat (2) @(negedge clk);
    check("rst_pre_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    go_pulse();
    check("rst_go_ignored", sha_start, 1'b0);
    repeat (15) @(negedge clk);
    check("rst_no_start", exp_q.size(), 0);
    lat = 2;
    load_bytes(GEN, 0, 79);
    push(EV_START, WIN_NONCE);
    push(EV_FOUND, WIN_NONCE);
    go_pulse();
    wait_empty(100);
    check("rst_reload_found", found, 1'b1);
    check("rst_reload_nonce", nonce_out, WIN_NONCE);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
